// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG DCT feeder: FSM states and block geometry.
package jpeg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH0,
    ST_FETCH1,
    ST_CAPTURE,
    ST_PRESENT
  } feeder_state_t;

  localparam int         BLOCK_ROWS    = 8;
  localparam int         WORDS_PER_ROW = 2;
  localparam logic [7:0] PIXEL_OFFSET  = 8'h80;

endpackage

// File: rtl/jpeg_row_unpack.sv
// Splits one 32-bit BRAM word into four pixels, optionally level-shifted by -128.
module jpeg_row_unpack
  import jpeg_pkg::*;
#(
  parameter bit LEVEL_SHIFT = 1'b1
) (
  input  logic [31:0] word_i,
  output logic [31:0] pix_o
);

  localparam int NUM_LANES = 4;

  // Flipping the MSB of an unsigned byte yields its two's-complement value minus 128.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    if (LEVEL_SHIFT) begin : g_shift
      assign pix_o[8*i +: 8] = word_i[8*i +: 8] ^ PIXEL_OFFSET;
    end else begin : g_raw
      assign pix_o[8*i +: 8] = word_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/jpeg_dct_feeder.sv
// Fetches one 8x8 block from the input BRAM row by row, level-shifts the
// pixels and hands each 64-bit row to the DCT over a valid/ready handshake.
module jpeg_dct_feeder
  import jpeg_pkg::*;
#(
  parameter int BANK_W      = 5,
  parameter bit LEVEL_SHIFT = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [BANK_W-1:0] bank_i,
  output logic              busy_o,
  output logic [BANK_W+3:0] bram_addr_o,
  output logic              bram_rd_o,
  input  logic [31:0]       bram_data_i,
  output logic [63:0]       row_o,
  output logic              row_valid_o,
  input  logic              row_ready_i,
  output logic [2:0]        row_idx_o,
  output logic              last_row_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  blk_cnt_o
);

  localparam logic [2:0] LAST_ROW = 3'(BLOCK_ROWS - 1);

  feeder_state_t     state;
  logic [BANK_W-1:0] bank_q;
  logic [31:0]       pix;

  // One unpacker serves both halves of the row; the FSM picks where it lands.
  jpeg_row_unpack #(.LEVEL_SHIFT(LEVEL_SHIFT)) u_unpack (
    .word_i (bram_data_i),
    .pix_o  (pix)
  );

  // Row sequencer; every output is registered and reflects the state it enters.
  // row_idx_o doubles as the row counter so it is stable while a row is offered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      bank_q      <= '0;
      busy_o      <= 1'b0;
      bram_rd_o   <= 1'b0;
      bram_addr_o <= '0;
      row_o       <= '0;
      row_valid_o <= 1'b0;
      row_idx_o   <= '0;
      last_row_o  <= 1'b0;
      done_o      <= 1'b0;
      blk_cnt_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            bank_q      <= bank_i;
            row_idx_o   <= '0;
            busy_o      <= 1'b1;
            bram_rd_o   <= 1'b1;
            bram_addr_o <= {bank_i, 3'd0, 1'b0};
            state       <= ST_FETCH0;
          end
        end
        ST_FETCH0: begin
          bram_addr_o <= {bank_q, row_idx_o, 1'b1};
          state       <= ST_FETCH1;
        end
        ST_FETCH1: begin
          // Word 0 (pixels 0-3) returns now, one cycle after its read.
          row_o[63:32] <= pix;
          bram_rd_o    <= 1'b0;
          state        <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          row_o[31:0] <= pix;
          row_valid_o <= 1'b1;
          last_row_o  <= (row_idx_o == LAST_ROW);
          state       <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (row_ready_i) begin
            row_valid_o <= 1'b0;
            last_row_o  <= 1'b0;
            if (row_idx_o == LAST_ROW) begin
              // start_i is not looked at here, so a coincident start is dropped.
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              blk_cnt_o <= blk_cnt_o + CNT_W'(1);
              state     <= ST_IDLE;
            end else begin
              row_idx_o   <= row_idx_o + 3'd1;
              bram_rd_o   <= 1'b1;
              bram_addr_o <= {bank_q, row_idx_o + 3'd1, 1'b0};
              state       <= ST_FETCH0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_dct_feeder.sv
// Directed bench for jpeg_dct_feeder with a transaction-level scoreboard.
module tb_jpeg_dct_feeder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  bank_i = '0;
  logic        row_ready_i = 1'b0;
  logic [31:0] bram_data_i = '0;
  logic [31:0] raw_data = '0;

  logic        busy_o, bram_rd_o, row_valid_o, last_row_o, done_o;
  logic [8:0]  bram_addr_o;
  logic [63:0] row_o;
  logic [2:0]  row_idx_o;
  logic [15:0] blk_cnt_o;

  logic        r_busy, r_rd, r_valid, r_last, r_done;
  logic [8:0]  r_addr;
  logic [63:0] r_row;
  logic [2:0]  r_idx;
  logic [2:0]  r_cnt;

  logic [31:0] mem [0:511];

  int n_vec = 0;
  int n_err = 0;

  jpeg_dct_feeder u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .bank_i(bank_i),
    .busy_o(busy_o), .bram_addr_o(bram_addr_o), .bram_rd_o(bram_rd_o),
    .bram_data_i(bram_data_i), .row_o(row_o), .row_valid_o(row_valid_o),
    .row_ready_i(row_ready_i), .row_idx_o(row_idx_o), .last_row_o(last_row_o),
    .done_o(done_o), .blk_cnt_o(blk_cnt_o)
  );

  // Second instance: raw bytes and a 3-bit counter so wrap-around is reachable.
  jpeg_dct_feeder #(.BANK_W(5), .LEVEL_SHIFT(1'b0), .CNT_W(3)) u_raw (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .bank_i(bank_i),
    .busy_o(r_busy), .bram_addr_o(r_addr), .bram_rd_o(r_rd),
    .bram_data_i(raw_data), .row_o(r_row), .row_valid_o(r_valid),
    .row_ready_i(row_ready_i), .row_idx_o(r_idx), .last_row_o(r_last),
    .done_o(r_done), .blk_cnt_o(r_cnt)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous-read BRAM models, one per instance.
  always @(posedge clk_i) begin
    if (bram_rd_o) bram_data_i <= mem[bram_addr_o];
    if (r_rd)      raw_data    <= mem[r_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: block/row bookkeeping from the protocol rules, checked every cycle.
  initial begin
    bit          m_act, m_done;
    int          m_cnt, m_row;
    logic [4:0]  m_bank;
    logic [8:0]  addr_q [$];
    logic [31:0] w0, w1;
    m_act = 0; m_done = 0; m_cnt = 0; m_row = 0; m_bank = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        m_act = 0; m_done = 0; m_cnt = 0; m_row = 0;
        addr_q.delete();
      end else begin
        chk("busy", busy_o, m_act);
        chk("done", done_o, m_done);
        chk("blk_cnt", blk_cnt_o, m_cnt % 65536);
        chk("raw_blk_cnt", r_cnt, m_cnt % 8);
        chk("last_row", last_row_o, row_valid_o && (row_idx_o == 3'd7));
        if (!m_act) chk("valid_when_idle", row_valid_o, 0);
        m_done = 0;
        if (bram_rd_o) begin
          chk("read_expected", addr_q.size() > 0, 1);
          if (addr_q.size() > 0) chk("bram_addr", bram_addr_o, addr_q.pop_front());
        end
        if (m_act && row_valid_o && row_ready_i) begin
          w0 = mem[{m_bank, m_row[2:0], 1'b0}];
          w1 = mem[{m_bank, m_row[2:0], 1'b1}];
          chk("row_idx", row_idx_o, m_row);
          chk("row", row_o, {w0, w1} ^ {8{8'h80}});
          chk("raw_row", r_row, {w0, w1});
          if (m_row == 7) begin
            m_act = 0; m_done = 1; m_cnt++;
          end else begin
            m_row++;
          end
        end else if (!m_act && start_i) begin
          chk("reads_left_over", addr_q.size(), 0);
          m_act = 1; m_bank = bank_i; m_row = 0;
          for (int k = 0; k < 16; k++) addr_q.push_back({bank_i, 4'(k)});
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_rd"}, bram_rd_o, 0);
    chk({tag, "_addr"}, bram_addr_o, 0);
    chk({tag, "_row"}, row_o, 0);
    chk({tag, "_valid"}, row_valid_o, 0);
    chk({tag, "_idx"}, row_idx_o, 0);
    chk({tag, "_last"}, last_row_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_cnt"}, blk_cnt_o, 0);
  endtask

  // One block with ready pulsed per row; optional hold on a row and a stray start.
  task automatic run_block(input logic [4:0] bank, input int hold_idx, input int hold_n,
                           input int poke_idx, output int cyc,
                           output logic [63:0] row0, output logic [63:0] raw0);
    logic [63:0] snap;
    int w;
    @(posedge clk_i); #1;
    bank_i = bank; start_i = 1'b1; row_ready_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0; bank_i = 5'd1;
    cyc = 0; row0 = '0; raw0 = '0;
    chk("first_read_en", bram_rd_o, 1);
    chk("first_read_addr", bram_addr_o, {bank, 4'h0});
    for (int r = 0; r < 8; r++) begin
      w = 0;
      while (!row_valid_o && w < 20) begin
        @(posedge clk_i); #1; cyc++; w++;
      end
      chk("row_valid_wait", row_valid_o, 1);
      if (r == 0) begin row0 = row_o; raw0 = r_row; end
      if (r == poke_idx) begin
        start_i = 1'b1; bank_i = 5'd1;
        @(posedge clk_i); #1; cyc++;
        start_i = 1'b0;
      end
      if (r == hold_idx) begin
        snap = row_o;
        for (int h = 0; h < hold_n; h++) begin
          @(posedge clk_i); #1; cyc++;
          chk("hold_row", row_o, snap);
          chk("hold_idx", row_idx_o, r);
          chk("hold_valid", row_valid_o, 1);
          chk("hold_no_read", bram_rd_o, 0);
        end
      end
      row_ready_i = 1'b1;
      @(posedge clk_i); #1; cyc++;
      row_ready_i = 1'b0;
      if (r < 7) chk("next_fetch", bram_rd_o, 1);
      else       chk("done_pulse", done_o, 1);
    end
  endtask

  // Ready held high; optionally a start coinciding with the final handshake.
  task automatic run_fast(input logic [4:0] bank, input bit poke_last);
    int n;
    @(posedge clk_i); #1;
    row_ready_i = 1'b1; bank_i = bank; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; n = 0;
    while (!done_o && n < 40) begin
      start_i = poke_last && row_valid_o && (row_idx_o == 3'd7);
      @(posedge clk_i); #1; n++;
    end
    start_i = 1'b0;
    chk("fast_done_seen", done_o, 1);
    chk("fast_latency", n, 32);
    @(posedge clk_i); #1;
    chk("start_on_last_ignored", busy_o, 0);
    row_ready_i = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [63:0] row0, raw0;
    for (int i = 0; i < 512; i++) mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    for (int k = 0; k < 16; k++)
      mem[80 + k] = {8'(4*k), 8'(4*k + 1), 8'(4*k + 2), 8'(4*k + 3)};
    mem[32] = 32'h007F80FF;
    mem[33] = 32'h00FF7F80;

    #12;
    check_zero("reset");
    @(posedge clk_i); #1; rst_ni = 1'b1;

    // Ramp block in bank 5.
    run_block(5'd5, -1, 0, -1, cyc, row0, raw0);
    chk("t1_latency", cyc, 32);
    chk("t1_row0", row0, 64'h8081828384858687);
    chk("t1_raw_row0", raw0, 64'h0001020304050607);
    chk("t1_cnt", blk_cnt_o, 1);

    // Level-shift boundary bytes.
    run_block(5'd2, -1, 0, -1, cyc, row0, raw0);
    chk("t2_shift_row0", row0, 64'h80FF007F807FFF00);
    chk("t2_raw_row0", raw0, 64'h007F80FF00FF7F80);

    // Backpressure on row 3 for 10 cycles.
    run_block(5'd3, 3, 10, -1, cyc, row0, raw0);
    chk("t3_latency", cyc, 42);

    // Stray start with another bank during row 2.
    run_block(5'd7, -1, 0, 2, cyc, row0, raw0);
    chk("t4_latency", cyc, 33);
    chk("t4_cnt", blk_cnt_o, 4);

    // Reset in the middle of row 5.
    @(posedge clk_i); #1;
    bank_i = 5'd4; start_i = 1'b1; row_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int w = 0; w < 40 && !(row_valid_o && row_idx_o == 3'd5); w++) begin
      @(posedge clk_i); #1;
    end
    chk("t5_reached_row5", row_idx_o, 5);
    #2 rst_ni = 1'b0;
    #1 check_zero("midblock_reset");
    row_ready_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1; rst_ni = 1'b1;
    run_block(5'd6, -1, 0, -1, cyc, row0, raw0);
    chk("t5_row0", row0, {mem[96], mem[97]} ^ {8{8'h80}});
    chk("t5_cnt", blk_cnt_o, 1);

    // Back-to-back blocks with ready held high; raw counter wraps after 8.
    for (int b = 0; b < 7; b++) run_fast(5'(b + 8), b == 2);
    chk("t6_cnt", blk_cnt_o, 8);
    chk("t6_raw_wrap", r_cnt, 0);

    repeat (3) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
